// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C byte engine driven by register-block command/config outputs.
// Four ticks per bit; SCL/SDA are open-drain style (1 = release, 0 = pull low).
module i2c_master_ctrl (
    input  logic       CLOCK_i,
    input  logic       RESET_i,
    input  logic [7:0] PRESCALER_i,
    input  logic [7:0] CMD_i,
    input  logic [7:0] ADDRESS_RW_i,
    input  logic [7:0] TX_DATA_i,
    input  logic       TX_EMPTY_i,
    input  logic       RX_FULL_i,
    input  logic       SDA_i,
    output logic       SCL_o,
    output logic       SDA_o,
    output logic       TX_RD_o,
    output logic [7:0] RX_DATA_o,
    output logic       RX_WR_o,
    output logic       CMD_ACK_o,
    output logic [7:0] STATUS_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_STOP
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_presc, r_cnt, r_shift, r_rx_data;
    logic [3:0] r_bytes;
    logic [2:0] r_bit;
    logic [1:0] r_phase;
    logic       r_rw, r_sample, r_tx_rd, r_rx_wr, r_cmd_ack;
    logic       r_busy, r_nack, r_done, r_und, r_ovf;
    logic       w_tick, w_end, w_last_bit, w_last_byte, w_accept, w_scl, w_sda, w_unused;

    assign w_tick      = (r_state != S_IDLE) && (r_cnt == r_presc);
    assign w_end       = w_tick && (r_phase == 2'd3);
    assign w_last_bit  = (r_bit == 3'd7);
    assign w_last_byte = (r_bytes == 4'd0);
    assign w_accept    = (r_state == S_IDLE) && CMD_i[0];
    assign w_unused    = &{1'b0, CMD_i[3:1]};

    always_comb begin
        w_next = r_state;
        w_scl  = r_phase[0] ^ r_phase[1];
        w_sda  = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_scl  = 1'b1;
                w_next = CMD_i[0] ? S_START : S_IDLE;
            end
            S_START: begin
                w_scl  = 1'b1;
                w_sda  = ~r_phase[1];
                w_next = w_end ? S_ADDR : S_START;
            end
            S_ADDR: begin
                w_sda  = r_shift[7];
                w_next = (w_end && w_last_bit) ? S_ADDR_ACK : S_ADDR;
            end
            S_ADDR_ACK:
                w_next = !w_end ? S_ADDR_ACK : r_sample ? S_STOP : r_rw ? S_RD_DATA :
                         TX_EMPTY_i ? S_STOP : S_WR_DATA;
            S_WR_DATA: begin
                w_sda  = r_shift[7];
                w_next = (w_end && w_last_bit) ? S_WR_ACK : S_WR_DATA;
            end
            S_WR_ACK:
                w_next = !w_end ? S_WR_ACK :
                         (r_sample || w_last_byte || TX_EMPTY_i) ? S_STOP : S_WR_DATA;
            S_RD_DATA:
                w_next = (w_end && w_last_bit) ? S_RD_ACK : S_RD_DATA;
            S_RD_ACK: begin
                w_sda  = w_last_byte;
                w_next = !w_end ? S_RD_ACK : w_last_byte ? S_STOP : S_RD_DATA;
            end
            S_STOP: begin
                w_scl  = (r_phase != 2'd0);
                w_sda  = r_phase[1];
                w_next = w_end ? S_IDLE : S_STOP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_i or negedge RESET_i) begin
        if (!RESET_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge CLOCK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            r_presc   <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_bytes   <= '0;
            r_bit     <= '0;
            r_phase   <= '0;
            r_rw      <= 1'b0;
            r_sample  <= 1'b1;
            r_tx_rd   <= 1'b0;
            r_rx_wr   <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_busy    <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_und     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_tx_rd   <= 1'b0;
            r_rx_wr   <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_cnt     <= (r_state == S_IDLE || w_tick) ? 8'd0 : r_cnt + 8'd1;
            if (w_tick)
                r_phase <= r_phase + 2'd1;
            if (w_accept) begin
                r_presc   <= PRESCALER_i;
                r_shift   <= ADDRESS_RW_i;
                r_rw      <= ADDRESS_RW_i[0];
                r_bytes   <= CMD_i[7:4];
                r_bit     <= 3'd0;
                r_phase   <= 2'd0;
                r_cmd_ack <= 1'b1;
                r_busy    <= 1'b1;
                r_nack    <= 1'b0;
                r_done    <= 1'b0;
                r_und     <= 1'b0;
                r_ovf     <= 1'b0;
            end
            // SDA_i is taken at the end of the first SCL-high phase
            if (w_tick && r_phase == 2'd1) begin
                r_sample <= SDA_i;
                if (r_state == S_RD_DATA)
                    r_shift <= {r_shift[6:0], SDA_i};
            end
            if (w_end) begin
                case (r_state)
                    S_ADDR, S_WR_DATA: begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bit   <= r_bit + 3'd1;
                    end
                    S_RD_DATA: begin
                        r_bit <= r_bit + 3'd1;
                        if (w_last_bit && !RX_FULL_i) begin
                            r_rx_data <= r_shift;
                            r_rx_wr   <= 1'b1;
                        end
                        if (w_last_bit && RX_FULL_i)
                            r_ovf <= 1'b1;
                    end
                    S_ADDR_ACK, S_WR_ACK: begin
                        if (r_sample)
                            r_nack <= 1'b1;
                        else if (r_state == S_ADDR_ACK ? !r_rw : !w_last_byte) begin
                            if (r_state == S_WR_ACK)
                                r_bytes <= r_bytes - 4'd1;
                            if (TX_EMPTY_i)
                                r_und <= 1'b1;
                            else begin
                                r_shift <= TX_DATA_i;
                                r_tx_rd <= 1'b1;
                            end
                        end
                    end
                    S_RD_ACK:
                        if (!w_last_byte)
                            r_bytes <= r_bytes - 4'd1;
                    S_STOP: begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SCL_o     = w_scl;
    assign SDA_o     = w_sda;
    assign TX_RD_o   = r_tx_rd;
    assign RX_WR_o   = r_rx_wr;
    assign RX_DATA_o = r_rx_data;
    assign CMD_ACK_o = r_cmd_ack;
    assign STATUS_o  = {3'b000, r_ovf, r_und, r_done, r_nack, r_busy};
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench with a bit-indexed slave model and a small TX FIFO model.
module tb_i2c_master_ctrl;
    logic       CLOCK_i = 1'b0;
    logic       RESET_i = 1'b0;
    logic [7:0] PRESCALER_i = '0, CMD_i = '0, ADDRESS_RW_i = '0, TX_DATA_i;
    logic       TX_EMPTY_i, RX_FULL_i = 1'b0, SDA_i = 1'b1;
    logic       SCL_o, SDA_o, TX_RD_o, RX_WR_o, CMD_ACK_o;
    logic [7:0] RX_DATA_o, STATUS_o;

    i2c_master_ctrl dut (
        .CLOCK_i(CLOCK_i), .RESET_i(RESET_i), .PRESCALER_i(PRESCALER_i), .CMD_i(CMD_i),
        .ADDRESS_RW_i(ADDRESS_RW_i), .TX_DATA_i(TX_DATA_i), .TX_EMPTY_i(TX_EMPTY_i),
        .RX_FULL_i(RX_FULL_i), .SDA_i(SDA_i), .SCL_o(SCL_o), .SDA_o(SDA_o), .TX_RD_o(TX_RD_o),
        .RX_DATA_o(RX_DATA_o), .RX_WR_o(RX_WR_o), .CMD_ACK_o(CMD_ACK_o), .STATUS_o(STATUS_o)
    );

    always #5 CLOCK_i = ~CLOCK_i;

    int         n_chk = 0, n_pass = 0;
    int         n_ack, n_tx, n_rx, rises, cyc = 0, tx_head = 0, tx_cnt = 0;
    int         t_rise[64];
    logic [7:0] rx[4];
    logic [7:0] txq[4];
    logic [7:0] busy_seen;
    logic [0:63] cap, slv;
    logic       prev_scl = 1'b1, auto_clr = 1'b1;

    assign TX_EMPTY_i = (tx_cnt == 0);
    assign TX_DATA_i  = txq[tx_head % 4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One cycle: also emulates the register block, TX FIFO and bus slave.
    task automatic step();
        @(negedge CLOCK_i);
        cyc++;
        if (CMD_ACK_o) begin
            n_ack++;
            if (auto_clr) CMD_i[0] = 1'b0;
        end
        if (TX_RD_o) begin
            n_tx++;
            if (tx_cnt > 0) begin tx_head++; tx_cnt--; end
        end
        if (RX_WR_o) begin
            if (n_rx < 4) rx[n_rx] = RX_DATA_o;
            n_rx++;
        end
        if (!prev_scl && SCL_o && rises < 64) begin
            cap[rises] = SDA_o;
            t_rise[rises] = cyc;
            rises++;
        end
        if (prev_scl && !SCL_o) SDA_i = (rises < 64) ? slv[rises] : 1'b1;
        prev_scl = SCL_o;
    endtask

    task automatic arm(input logic [7:0] p, input logic [7:0] cmd, input logic [7:0] addr, input logic hold);
        n_ack = 0; n_tx = 0; n_rx = 0; rises = 0;
        cap = '1; prev_scl = SCL_o; SDA_i = 1'b1; auto_clr = !hold;
        PRESCALER_i = p; ADDRESS_RW_i = addr; CMD_i = cmd;
    endtask

    task automatic finish_run();
        int k = 0;
        while (n_ack == 0 && k < 100) begin step(); k++; end
        busy_seen = STATUS_o;
        while (STATUS_o[0] && k < 20000) begin step(); k++; end
        CMD_i = '0;
        check("busy_cleared", 32'(STATUS_o[0]), 0);
        repeat (6) step();
    endtask

    task automatic load_tx(input int n, input logic [7:0] b0);
        txq[0] = b0; tx_head = 0; tx_cnt = n;
    endtask

    initial begin
        repeat (2) step();
        check("rst_scl", 32'(SCL_o), 1);
        check("rst_sda", 32'(SDA_o), 1);
        check("rst_status", 32'(STATUS_o), 0);
        check("rst_rxdata", 32'(RX_DATA_o), 0);
        check("rst_strobes", 32'({TX_RD_o, RX_WR_o, CMD_ACK_o}), 0);
        RESET_i = 1'b1;
        step();

        // single-byte write, P=0
        load_tx(1, 8'h55);
        slv = '1; slv[8] = 1'b0; slv[17] = 1'b0;
        arm(8'd0, 8'h01, 8'hA0, 1'b0);
        finish_run();
        check("wr_busy", 32'(busy_seen), 32'h01);
        check("wr_ack_cnt", n_ack, 1);
        check("wr_addr_bits", 32'(cap[0+:8]), 32'hA0);
        check("wr_data_bits", 32'(cap[9+:8]), 32'h55);
        check("wr_ack_release", 32'(cap[17]), 1);
        check("wr_stop_rise", 32'(cap[18]), 0);
        check("wr_rises", rises, 19);
        check("wr_pops", n_tx, 1);
        check("wr_period", t_rise[1] - t_rise[0], 4);
        check("wr_status", 32'(STATUS_o), 32'h04);
        check("wr_idle_bus", 32'({SCL_o, SDA_o}), 32'h3);

        // two-byte read, P=3
        slv = '1; slv[8] = 1'b0; slv[9+:8] = 8'h3C; slv[18+:8] = 8'hC3;
        arm(8'd3, 8'h11, 8'hA1, 1'b0);
        finish_run();
        check("rd_addr_bits", 32'(cap[0+:8]), 32'hA1);
        check("rd_push_cnt", n_rx, 2);
        check("rd_byte0", 32'(rx[0]), 32'h3C);
        check("rd_byte1", 32'(rx[1]), 32'hC3);
        check("rd_master_ack", 32'(cap[17]), 0);
        check("rd_master_nack", 32'(cap[26]), 1);
        check("rd_period", t_rise[5] - t_rise[4], 16);
        check("rd_status", 32'(STATUS_o), 32'h04);

        // address NACK
        load_tx(1, 8'h77);
        slv = '1;
        arm(8'd1, 8'h01, 8'hA0, 1'b0);
        finish_run();
        check("nack_pops", n_tx, 0);
        check("nack_rises", rises, 10);
        check("nack_stop_rise", 32'(cap[9]), 0);
        check("nack_status", 32'(STATUS_o), 32'h06);

        // two-byte write with only one byte queued
        load_tx(1, 8'h5A);
        slv = '1; slv[8] = 1'b0; slv[17] = 1'b0;
        arm(8'd0, 8'h11, 8'hA0, 1'b0);
        finish_run();
        check("und_data_bits", 32'(cap[9+:8]), 32'h5A);
        check("und_pops", n_tx, 1);
        check("und_stop_rise", 32'(cap[18]), 0);
        check("und_status", 32'(STATUS_o), 32'h0C);

        // read into full RX FIFO, CMD bit0 held high for the whole transfer
        RX_FULL_i = 1'b1;
        slv = '1; slv[8] = 1'b0; slv[9+:8] = 8'h96;
        arm(8'd0, 8'h01, 8'hA1, 1'b1);
        finish_run();
        RX_FULL_i = 1'b0;
        check("ovf_push_cnt", n_rx, 0);
        check("ovf_single_ack", n_ack, 1);
        check("ovf_master_nack", 32'(cap[17]), 1);
        check("ovf_status", 32'(STATUS_o), 32'h14);

        // asynchronous reset in the middle of the address byte
        load_tx(1, 8'h55);
        slv = '1; slv[8] = 1'b0; slv[17] = 1'b0;
        arm(8'd1, 8'h01, 8'hA0, 1'b0);
        begin
            int k = 0;
            while (rises < 3 && k < 500) begin step(); k++; end
        end
        check("mid_busy", 32'(STATUS_o), 32'h01);
        RESET_i = 1'b0;
        #1;
        check("mid_rst_bus", 32'({SCL_o, SDA_o}), 32'h3);
        check("mid_rst_status", 32'(STATUS_o), 0);
        step();
        RESET_i = 1'b1;
        step();
        load_tx(1, 8'h55);
        arm(8'd0, 8'h01, 8'hA0, 1'b0);
        finish_run();
        check("post_rst_addr", 32'(cap[0+:8]), 32'hA0);
        check("post_rst_data", 32'(cap[9+:8]), 32'h55);
        check("post_rst_status", 32'(STATUS_o), 32'h04);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
